// File: rtl/scanline_object_renderer.sv
`default_nettype none
// ============================================================================
// Module   : scanline_object_renderer
// Purpose  : Hblank object-table scan into a ping-pong slot buffer, with a
//            registered per-pixel hit/colour lookup on the front bank.
// Revision : 1.0
// ============================================================================
module scanline_object_renderer #(
    parameter int MAX_OBJECTS = 64,
    parameter int LINE_SLOTS  = 8,
    parameter int OBJ_SIZE    = 8,
    parameter int COORD_W     = 9,
    parameter int COLOR_W     = 12,
    parameter logic [4*COLOR_W-1:0] PALETTE = {12'hF00, 12'h0F0, 12'h00F, 12'hFF0}
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [MAX_OBJECTS*32-1:0] obj_table,
    input  logic                     line_start,
    input  logic [9:0]               line_y,
    input  logic [9:0]               x,
    input  logic                     active,
    input  logic                     ovf_clear,
    output logic                     obj_hit,
    output logic [COLOR_W-1:0]       obj_color,
    output logic                     scan_busy,
    output logic [3:0]               line_count,
    output logic                     line_ovf,
    output logic                     ovf_sticky
);

    localparam int c_IDX_W  = $clog2(MAX_OBJECTS);
    localparam int c_SLOT_W = $clog2(LINE_SLOTS);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_SCAN = 2'd1,
        c_SWAP = 2'd2
    } state_t;

    state_t               r_state;
    logic [9:0]           r_tgtY;
    logic [c_IDX_W-1:0]   r_idx;
    logic [3:0]           r_backCnt;
    logic                 r_ovfPend;
    logic                 r_bankSel;
    logic [COORD_W-1:0]   r_slotX [2][LINE_SLOTS];
    logic [1:0]           r_slotC [2][LINE_SLOTS];
    logic                 r_slotV [2][LINE_SLOTS];

    logic [31:0]          w_entry;
    logic [9:0]           w_entY;
    logic                 w_match;
    logic                 w_startBank;
    logic                 w_hit;
    logic [1:0]           w_cid;
    logic                 w_unused;

    assign w_entry  = obj_table[int'(r_idx)*32 +: 32];
    assign w_entY   = {1'b0, w_entry[22:14]};
    // Widened by one bit so objects near the bottom edge do not wrap to line 0
    assign w_match  = w_entry[5] && (r_tgtY >= w_entY) && (r_tgtY < w_entY + 10'(OBJ_SIZE));
    assign w_unused = ^{w_entry[13:8], w_entry[4:0]};

    // A restart arriving in SWAP must clear the bank that is about to become back
    assign w_startBank = (r_state == c_SWAP) ? r_bankSel : ~r_bankSel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= c_IDLE;
            r_tgtY     <= '0;
            r_idx      <= '0;
            r_backCnt  <= '0;
            r_ovfPend  <= 1'b0;
            r_bankSel  <= 1'b0;
            scan_busy  <= 1'b0;
            line_count <= '0;
            line_ovf   <= 1'b0;
            ovf_sticky <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < LINE_SLOTS; s++)
                    r_slotV[b][s] <= 1'b0;
        end else begin
            if (r_state == c_SWAP) begin
                r_bankSel  <= ~r_bankSel;
                line_count <= r_backCnt;
                line_ovf   <= r_ovfPend;
                if (r_ovfPend)
                    ovf_sticky <= 1'b1;
                r_state    <= c_IDLE;
            end

            if (r_state == c_SCAN && !line_start) begin
                if (w_match) begin
                    if (r_backCnt < 4'(LINE_SLOTS)) begin
                        r_slotX[~r_bankSel][r_backCnt[c_SLOT_W-1:0]] <= w_entry[31:23];
                        r_slotC[~r_bankSel][r_backCnt[c_SLOT_W-1:0]] <= w_entry[7:6];
                        r_slotV[~r_bankSel][r_backCnt[c_SLOT_W-1:0]] <= 1'b1;
                        r_backCnt <= r_backCnt + 4'd1;
                    end else begin
                        r_ovfPend <= 1'b1;
                    end
                end
                r_idx <= r_idx + 1'b1;
                if (r_idx == c_IDX_W'(MAX_OBJECTS - 1)) begin
                    r_state   <= c_SWAP;
                    scan_busy <= 1'b0;
                end
            end

            if (line_start) begin
                r_tgtY    <= line_y;
                r_idx     <= '0;
                r_backCnt <= '0;
                r_ovfPend <= 1'b0;
                for (int s = 0; s < LINE_SLOTS; s++)
                    r_slotV[w_startBank][s] <= 1'b0;
                r_state   <= c_SCAN;
                scan_busy <= 1'b1;
            end

            if (ovf_clear)
                ovf_sticky <= 1'b0;
        end
    end

    // Descending walk so the lowest slot index (lowest table index) wins
    always_comb begin
        w_hit = 1'b0;
        w_cid = 2'd0;
        for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
            if (r_slotV[r_bankSel][s] &&
                (x >= {1'b0, r_slotX[r_bankSel][s]}) &&
                (x < {1'b0, r_slotX[r_bankSel][s]} + 10'(OBJ_SIZE))) begin
                w_hit = 1'b1;
                w_cid = r_slotC[r_bankSel][s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            obj_hit   <= 1'b0;
            obj_color <= '0;
        end else begin
            obj_hit   <= active && w_hit;
            obj_color <= (active && w_hit) ? PALETTE[(3 - int'(w_cid))*COLOR_W +: COLOR_W] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scanline_object_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scanline_object_renderer
// Purpose  : Directed self-checking bench for scanline_object_renderer.
// Revision : 1.0
// ============================================================================
module tb_scanline_object_renderer;

    logic           clk;
    logic           resetn;
    logic [64*32-1:0] obj_table;
    logic           line_start;
    logic [9:0]     line_y;
    logic [9:0]     x;
    logic           active;
    logic           ovf_clear;
    logic           obj_hit;
    logic [11:0]    obj_color;
    logic           scan_busy;
    logic [3:0]     line_count;
    logic           line_ovf;
    logic           ovf_sticky;

    int nCompared   = 0;
    int nMismatched = 0;
    int lastCnt     = 0;

    scanline_object_renderer dut (
        .clk        (clk),
        .resetn     (resetn),
        .obj_table  (obj_table),
        .line_start (line_start),
        .line_y     (line_y),
        .x          (x),
        .active     (active),
        .ovf_clear  (ovf_clear),
        .obj_hit    (obj_hit),
        .obj_color  (obj_color),
        .scan_busy  (scan_busy),
        .line_count (line_count),
        .line_ovf   (line_ovf),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setEntry(input int idx, input int ex, input int ey, input int col, input int act);
        logic [8:0] xx;
        logic [8:0] yy;
        logic [1:0] cc;
        logic       aa;
        xx = 9'(ex);
        yy = 9'(ey);
        cc = 2'(col);
        aa = 1'(act);
        obj_table[idx*32 +: 32] = {xx, yy, 6'd0, cc, aa, 5'd0};
    endtask

    task automatic pix(input string tag, input int px, input logic expHit, input logic [11:0] expCol);
        active = 1'b1;
        x      = 10'(px);
        tick();
        chk({tag, ".hit"}, 32'(obj_hit), 32'(expHit));
        chk({tag, ".col"}, 32'(obj_color), 32'(expCol));
    endtask

    // Pulse line_start, measure busy length, check counts just before and after the swap edge
    task automatic runScan(input string tag, input int y, input int expCnt, input logic expOvf);
        int cnt;
        line_start = 1'b1;
        line_y     = 10'(y);
        tick();
        line_start = 1'b0;
        cnt = 0;
        while (scan_busy && cnt < 200) begin
            cnt++;
            tick();
        end
        chk({tag, ".busyClks"}, 32'(cnt), 32'd64);
        chk({tag, ".preSwapCnt"}, 32'(line_count), 32'(lastCnt));
        tick();
        chk({tag, ".lineCount"}, 32'(line_count), 32'(expCnt));
        chk({tag, ".lineOvf"}, 32'(line_ovf), 32'(expOvf));
        lastCnt = expCnt;
    endtask

    initial begin
        resetn     = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        x          = '0;
        active     = 1'b0;
        ovf_clear  = 1'b0;
        for (int i = 0; i < 64; i++)
            obj_table[i*32 +: 32] = $urandom();

        // Reset state
        repeat (3) tick();
        chk("rst.hit", 32'(obj_hit), 0);
        chk("rst.col", 32'(obj_color), 0);
        chk("rst.busy", 32'(scan_busy), 0);
        chk("rst.cnt", 32'(line_count), 0);
        chk("rst.ovf", 32'(line_ovf), 0);
        chk("rst.sticky", 32'(ovf_sticky), 0);
        resetn = 1'b1;
        for (int px = 0; px < 640; px += 97)
            pix("rst.sweep", px, 1'b0, 12'h000);

        // Single object
        obj_table = '0;
        setEntry(0, 100, 50, 1, 1);
        runScan("single", 53, 1, 1'b0);
        pix("single.x99", 99, 1'b0, 12'h000);
        for (int px = 100; px <= 107; px++)
            pix("single.in", px, 1'b1, 12'h0F0);
        pix("single.x108", 108, 1'b0, 12'h000);
        active = 1'b0;
        x      = 10'd103;
        tick();
        chk("single.inactive.hit", 32'(obj_hit), 0);
        chk("single.inactive.col", 32'(obj_color), 0);

        // Vertical edges
        runScan("vedge49", 49, 0, 1'b0);
        pix("vedge49.x103", 103, 1'b0, 12'h000);
        runScan("vedge58", 58, 0, 1'b0);
        pix("vedge58.x100", 100, 1'b0, 12'h000);
        runScan("vedge57", 57, 1, 1'b0);
        pix("vedge57.x100", 100, 1'b1, 12'h0F0);
        pix("vedge57.x107", 107, 1'b1, 12'h0F0);

        // Overflow: ten objects on line 200, only the first eight are kept
        obj_table = '0;
        for (int i = 0; i < 10; i++)
            setEntry(i, 10 * i, 200, 3, 1);
        runScan("ovf", 200, 8, 1'b1);
        chk("ovf.sticky", 32'(ovf_sticky), 1);
        pix("ovf.x0", 0, 1'b1, 12'hFF0);
        pix("ovf.x77", 77, 1'b1, 12'hFF0);
        pix("ovf.x80", 80, 1'b0, 12'h000);
        pix("ovf.x90", 90, 1'b0, 12'h000);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf.cleared", 32'(ovf_sticky), 0);
        for (int i = 3; i < 10; i++)
            setEntry(i, 10 * i, 200, 3, 0);
        runScan("ovf3", 200, 3, 1'b0);
        chk("ovf3.sticky", 32'(ovf_sticky), 0);

        // Priority: lower table index wins
        obj_table = '0;
        setEntry(2, 300, 10, 0, 1);
        setEntry(5, 300, 10, 2, 1);
        runScan("prio", 12, 2, 1'b0);
        pix("prio.x303", 303, 1'b1, 12'hF00);

        // Restart mid-scan: only line 60 result appears
        obj_table = '0;
        setEntry(0, 20, 5, 3, 1);
        setEntry(1, 40, 60, 1, 1);
        line_start = 1'b1;
        line_y     = 10'd5;
        tick();
        line_start = 1'b0;
        repeat (19) tick();
        chk("restart.busyMid", 32'(scan_busy), 1);
        runScan("restart", 60, 1, 1'b0);
        pix("restart.x20", 20, 1'b0, 12'h000);
        pix("restart.x40", 40, 1'b1, 12'h0F0);

        // Reset at scan cycle 30
        line_start = 1'b1;
        line_y     = 10'd5;
        tick();
        line_start = 1'b0;
        repeat (29) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("midrst.busy", 32'(scan_busy), 0);
        chk("midrst.cnt", 32'(line_count), 0);
        pix("midrst.x40", 40, 1'b0, 12'h000);
        pix("midrst.x20", 20, 1'b0, 12'h000);
        repeat (80) tick();
        chk("midrst.idleBusy", 32'(scan_busy), 0);
        chk("midrst.idleCnt", 32'(line_count), 0);
        pix("midrst.late", 42, 1'b0, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
